// File: rtl/apb_req_pkg.sv
// Shared types and defaults for the APB requester and its address decoder.
// No logic: error codes, FSM state encoding, parameter defaults, counter sizing helper.
package apb_req_pkg;

  typedef enum logic [1:0] {
    APB_OK      = 2'd0,
    APB_SLVERR  = 2'd1,
    APB_DECERR  = 2'd2,
    APB_TIMEOUT = 2'd3
  } apb_err_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_req_state_e;

  localparam int DEF_ADDR_WIDTH   = 32;
  localparam int DEF_DATA_WIDTH   = 32;
  localparam int DEF_NO_OF_SLAVES = 7;
  localparam int DEF_SLAVE_SHIFT  = 12;
  localparam int DEF_TIMEOUT      = 16;

  // A disabled timeout (0) still needs a 1-bit counter to keep widths legal.
  function automatic int cnt_width(input int timeout);
    return (timeout > 0) ? $clog2(timeout + 1) : 1;
  endfunction

endpackage

// File: rtl/apb_addr_decoder.sv
// Combinational slave-index decode: one-hot select plus miss flag, zero latency.
// No backpressure; the full shifted address is compared so any upper-bit overflow is a miss.
module apb_addr_decoder #(
  parameter int IDX_WIDTH    = 32,
  parameter int NO_OF_SLAVES = 7
) (
  input  logic [IDX_WIDTH-1:0]    idx,
  output logic [NO_OF_SLAVES-1:0] sel,
  output logic                    miss
);

  always_comb begin
    miss = (idx >= IDX_WIDTH'(NO_OF_SLAVES));
    sel  = '0;
    for (int i = 0; i < NO_OF_SLAVES; i++) begin
      if (!miss && (idx == IDX_WIDTH'(i))) sel[i] = 1'b1;
    end
  end

endmodule

// File: rtl/apb_multi_requester.sv
// Valid/ready request port to APB requester; 3 cycles handshake-to-response plus one per wait state.
// One transaction outstanding: req_ready only in IDLE, response held until rsp_ready.
module apb_multi_requester
  import apb_req_pkg::*;
#(
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int NO_OF_SLAVES = DEF_NO_OF_SLAVES,
  parameter int SLAVE_SHIFT  = DEF_SLAVE_SHIFT,
  parameter int TIMEOUT      = DEF_TIMEOUT
) (
  input  logic                    pclock,
  input  logic                    preset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_err,
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic [DATA_WIDTH-1:0]   pwdata,
  output logic                    pwrite,
  output logic [NO_OF_SLAVES-1:0] psel_x,
  output logic                    penable,
  input  logic                    pready,
  input  logic [DATA_WIDTH-1:0]   prdata,
  input  logic                    pslverr
);

  localparam int CW = cnt_width(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  apb_req_state_e          state;
  logic [CW-1:0]           cnt;
  logic [ADDR_WIDTH-1:0]   idx_full;
  logic [NO_OF_SLAVES-1:0] dec_sel;
  logic                    dec_miss;

  assign idx_full = req_addr >> SLAVE_SHIFT;

  apb_addr_decoder #(
    .IDX_WIDTH   (ADDR_WIDTH),
    .NO_OF_SLAVES(NO_OF_SLAVES)
  ) u_dec (
    .idx (idx_full),
    .sel (dec_sel),
    .miss(dec_miss)
  );

  always_ff @(posedge pclock) begin
    if (preset) begin
      state     <= IDLE;
      cnt       <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= APB_OK;
      paddr     <= '0;
      pwdata    <= '0;
      pwrite    <= 1'b0;
      psel_x    <= '0;
      penable   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            if (dec_miss) begin
              // Decode misses never touch the bus, so paddr/pwrite keep their last value.
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= APB_DECERR;
              rsp_rdata <= '0;
            end else begin
              state  <= SETUP;
              cnt    <= '0;
              psel_x <= dec_sel;
              paddr  <= req_addr;
              pwrite <= req_write;
              pwdata <= req_write ? req_wdata : '0;
            end
          end
        end
        SETUP: begin
          penable <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          // pready is checked first so it wins on the timeout-limit cycle.
          if (pready) begin
            psel_x    <= '0;
            penable   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= pslverr ? APB_SLVERR : APB_OK;
            rsp_rdata <= (!pwrite && !pslverr) ? prdata : '0;
            state     <= RESP;
          end else if ((TIMEOUT != 0) && (cnt >= CNT_LAST)) begin
            psel_x    <= '0;
            penable   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= APB_TIMEOUT;
            rsp_rdata <= '0;
            state     <= RESP;
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_multi_requester.sv
// Bench for apb_multi_requester: directed plus random transactions against a transaction-level model.
// A second instance with the timeout disabled confirms an indefinitely stalled transfer stays open.
module tb_apb_multi_requester;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NS = 7;
  localparam int SS = 12;
  localparam int TO = 16;

  logic          pclock = 1'b0;
  logic          preset;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_err;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic          pwrite;
  logic [NS-1:0] psel_x;
  logic          penable, pready, pslverr;
  logic [DW-1:0] prdata;

  logic          z_req_valid, z_req_ready, z_rsp_valid, z_pwrite, z_penable;
  logic [DW-1:0] z_rsp_rdata, z_pwdata;
  logic [1:0]    z_rsp_err;
  logic [AW-1:0] z_paddr;
  logic [NS-1:0] z_psel_x;

  int total  = 0;
  int passed = 0;
  int fails  = 0;

  always #5 pclock = ~pclock;

  apb_multi_requester #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NO_OF_SLAVES(NS), .SLAVE_SHIFT(SS), .TIMEOUT(TO)
  ) dut (
    .pclock(pclock), .preset(preset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite), .psel_x(psel_x), .penable(penable),
    .pready(pready), .prdata(prdata), .pslverr(pslverr)
  );

  apb_multi_requester #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NO_OF_SLAVES(NS), .SLAVE_SHIFT(SS), .TIMEOUT(0)
  ) dut_z (
    .pclock(pclock), .preset(preset),
    .req_valid(z_req_valid), .req_ready(z_req_ready), .req_write(1'b0),
    .req_addr(32'h0000_1000), .req_wdata(32'h0),
    .rsp_valid(z_rsp_valid), .rsp_ready(1'b0), .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err),
    .paddr(z_paddr), .pwdata(z_pwdata), .pwrite(z_pwrite), .psel_x(z_psel_x), .penable(z_penable),
    .pready(1'b0), .prdata(32'hFFFF_FFFF), .pslverr(1'b0)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NS-1:0] exp_sel(input logic [AW-1:0] a);
    logic [NS-1:0] s;
    s = '0;
    if ((a >> SS) < NS) s[int'(a >> SS)] = 1'b1;
    return s;
  endfunction

  // Transaction-level model: outcome and response cycle are derived from the
  // address, the number of low-pready cycles the completer inserts (w) and its error flag.
  task automatic run_txn(input string tag, input logic wr, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input int w, input logic [DW-1:0] rd,
                         input logic se, input int bp);
    bit         miss = ((addr >> SS) >= NS);
    int         acc  = miss ? 0 : ((w >= TO) ? TO : w + 1);
    int         rk   = miss ? 1 : 2 + acc;
    logic [1:0] eerr = miss ? 2'd2 : ((w >= TO) ? 2'd3 : (se ? 2'd1 : 2'd0));
    logic [DW-1:0] erd   = (eerr == 2'd0 && !wr) ? rd : '0;
    logic [DW-1:0] epwd  = wr ? wdata : '0;
    @(negedge pclock);
    check({tag, " req_ready idle"}, req_ready, 1);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
    prdata = rd; pslverr = se; pready = 1'b0; rsp_ready = 1'b0;
    @(posedge pclock);
    for (int k = 1; k <= rk; k++) begin
      @(negedge pclock);
      req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_write = ~wr;
      if (k < rk) begin
        check($sformatf("%s c%0d psel_x", tag, k), psel_x, exp_sel(addr));
        check($sformatf("%s c%0d penable", tag, k), penable, (k >= 2));
        check($sformatf("%s c%0d rsp_valid", tag, k), rsp_valid, 0);
        check($sformatf("%s c%0d req_ready", tag, k), req_ready, 0);
        check($sformatf("%s c%0d paddr", tag, k), paddr, addr);
        check($sformatf("%s c%0d pwrite", tag, k), pwrite, wr);
        check($sformatf("%s c%0d pwdata", tag, k), pwdata, epwd);
        pready = (k >= 2) && (k - 2 == w);
      end else begin
        pready = 1'b0;
      end
    end
    for (int b = 0; b <= bp; b++) begin
      if (b > 0) @(negedge pclock);
      check($sformatf("%s r%0d rsp_valid", tag, b), rsp_valid, 1);
      check($sformatf("%s r%0d rsp_err", tag, b), rsp_err, eerr);
      check($sformatf("%s r%0d rsp_rdata", tag, b), rsp_rdata, erd);
      check($sformatf("%s r%0d psel_x", tag, b), psel_x, 0);
      check($sformatf("%s r%0d penable", tag, b), penable, 0);
      check($sformatf("%s r%0d req_ready", tag, b), req_ready, 0);
      rsp_ready = (b == bp);
    end
    @(negedge pclock);
    rsp_ready = 1'b0;
    check({tag, " done rsp_valid"}, rsp_valid, 0);
    check({tag, " done rsp_rdata"}, rsp_rdata, 0);
    check({tag, " done req_ready"}, req_ready, 1);
    if (!miss) begin
      check({tag, " hold paddr"}, paddr, addr);
      check({tag, " hold pwrite"}, pwrite, wr);
      check({tag, " hold pwdata"}, pwdata, epwd);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] a;
    int            w;
    preset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b0; pready = 1'b0; prdata = '0; pslverr = 1'b0; z_req_valid = 1'b0;
    repeat (2) @(posedge pclock);
    @(negedge pclock);
    check("reset req_ready", req_ready, 1);
    check("reset rsp_valid", rsp_valid, 0);
    check("reset rsp_rdata", rsp_rdata, 0);
    check("reset rsp_err", rsp_err, 0);
    check("reset psel_x", psel_x, 0);
    check("reset penable", penable, 0);
    check("reset paddr", paddr, 0);
    check("reset pwdata", pwdata, 0);
    check("reset pwrite", pwrite, 0);
    preset = 1'b0;

    // Timeout disabled: stalled transfer must remain in ACCESS.
    @(negedge pclock);
    z_req_valid = 1'b1;
    @(posedge pclock);
    @(negedge pclock);
    z_req_valid = 1'b0;
    repeat (40) @(negedge pclock);
    check("notimeout psel_x", z_psel_x, 7'b0000010);
    check("notimeout penable", z_penable, 1);
    check("notimeout rsp_valid", z_rsp_valid, 0);
    check("notimeout req_ready", z_req_ready, 0);

    run_txn("wr0wait", 1'b1, 32'h0000_2010, 32'hDEAD_BEEF, 0, 32'h0, 1'b0, 0);
    run_txn("rd3wait", 1'b0, 32'h0000_1004, 32'h0, 3, 32'h1234_5678, 1'b0, 1);
    run_txn("decmiss", 1'b0, 32'h0000_7000, 32'h0, 0, 32'hAAAA_5555, 1'b0, 0);
    run_txn("decmiss_hi", 1'b1, 32'h8000_0000, 32'h1111_2222, 0, 32'h0, 1'b0, 2);
    run_txn("timeout", 1'b0, 32'h0000_5008, 32'h0, 100, 32'hCAFE_F00D, 1'b0, 0);
    run_txn("limit_pready", 1'b0, 32'h0000_4000, 32'h0, 15, 32'h0BAD_CAFE, 1'b0, 0);
    run_txn("slverr_bp", 1'b1, 32'h0000_6000, 32'h5A5A_5A5A, 1, 32'h0, 1'b1, 5);
    run_txn("slverr_rd", 1'b0, 32'h0000_6FFC, 32'h0, 0, 32'h7777_8888, 1'b1, 0);
    run_txn("idx0_rd", 1'b0, 32'h0000_0000, 32'h0, 2, 32'hFFFF_0001, 1'b0, 0);

    // Reset during ACCESS aborts the transfer without a response.
    @(negedge pclock);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_3000; pready = 1'b0;
    @(posedge pclock);
    repeat (3) begin
      @(negedge pclock);
      req_valid = 1'b0;
    end
    check("midreset pre penable", penable, 1);
    preset = 1'b1;
    @(posedge pclock);
    @(negedge pclock);
    preset = 1'b0;
    check("midreset psel_x", psel_x, 0);
    check("midreset penable", penable, 0);
    check("midreset rsp_valid", rsp_valid, 0);
    check("midreset req_ready", req_ready, 1);
    @(negedge pclock);
    check("midreset after rsp_valid", rsp_valid, 0);
    check("midreset after req_ready", req_ready, 1);
    run_txn("post_reset", 1'b1, 32'h0000_3020, 32'h0F0F_0F0F, 1, 32'h0, 1'b0, 0);

    for (int t = 0; t < 30; t++) begin
      a = (AW'($urandom_range(0, 8)) << SS) | (AW'($urandom_range(0, 4095)) & ~AW'(3));
      if ($urandom_range(0, 9) == 0) a[AW-1 - $urandom_range(0, 3)] = 1'b1;
      w = ($urandom_range(0, 9) == 0) ? $urandom_range(16, 20) : $urandom_range(0, 5);
      run_txn($sformatf("rnd%0d", t), 1'($urandom), a, $urandom, w, $urandom,
              1'($urandom_range(0, 3) == 0), $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
